arbiter_vc: RTL and testbench
=============================

# arbiter_vc

Transmit-side arbiter that drains the VC0 and VC1 virtual-channel FIFOs and forwards each word to one of two downstream destination FIFOs (D0/D1). It sits between the initial logic's VC FIFOs and the destination demux/FIFO stage. VC0 has strict priority, with a starvation guard that guarantees VC1 progress. Destination back-pressure is honoured per word, so one blocked head never stalls the other channel.

## Interface
- data_width, 6, word width; bit [data_width-1] selects destination (0→D0, 1→D1)
- STARVE_LIMIT, 4, maximum consecutive VC0 grants while VC1 is eligible (1..15)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- init  in  1  holds arbiter in INIT (no grants) while high
- empty_fifo_VC0 / empty_fifo_VC1  in  1  VC FIFO empty flags
- data_arbitro_VC0 / data_arbitro_VC1  in  data_width  head word of each VC FIFO (first-word-fall-through, valid when not empty)
- pause_D0 / pause_D1  in  1  destination back-pressure (almost_full or full)
- pop_VC0_fifo / pop_VC1_fifo  out  1  combinational pop, at most one high per cycle
- push_D0 / push_D1  out  1  registered push to destination, at most one high per cycle
- data_out_arbitro  out  data_width  registered word accompanying push
- idle_out  out  1  registered, high in IDLE
- active_out  out  1  registered, high in ACTIVE

## Operation
- FSM states: RESET, INIT, IDLE, ACTIVE.
  - RESET → INIT when reset low and init high; RESET → IDLE when reset low and init low.
  - Any state → INIT while init high (reset has priority over init).
  - IDLE ↔ ACTIVE: next state is ACTIVE if either VC FIFO is non-empty, otherwise IDLE.
- Grants are permitted only in IDLE and ACTIVE.
- Eligibility of VCx: not empty_fifo_VCx, and the pause input of the destination selected by data_arbitro_VCx[data_width-1] is low.
- Grant rule:
  - VC0 eligible only → pop VC0.
  - VC1 eligible only → pop VC1.
  - Both eligible → pop VC0 unless starve_cnt == STARVE_LIMIT, in which case pop VC1.
- starve_cnt (4 bits):
  - +1 on each VC0 grant while VC1 is eligible.
  - Cleared on any VC1 grant, in any cycle VC1 is not eligible, and in RESET/INIT.
  - Saturates at STARVE_LIMIT.
- On a pop, the head word is registered into data_out_arbitro and push_Dx is asserted on the next cycle for the destination given by the word's MSB.
- When nothing is pushed, data_out_arbitro holds its last value.
- Pause is sampled in the same cycle as the pop. A word that has already been popped is always pushed, even if pause rises on the following cycle; the destination's almost_full margin absorbs it.

## Timing
- Reset values:
  - pop_VC0_fifo = pop_VC1_fifo = 0 (forced while reset is high).
  - push_D0 = push_D1 = 0.
  - data_out_arbitro = 0, idle_out = 0, active_out = 0, starve_cnt = 0, state = RESET.
- Latency: pop in cycle N → push_Dx and data_out_arbitro valid in cycle N+1.
- Sustained throughput: one word per cycle.
- Simultaneous events:
  - Pause rising in the same cycle as a would-be pop blocks that pop.
  - empty deasserting in cycle N makes the VC eligible in cycle N.
- Reset mid-transfer: a word popped in the cycle before reset asserts is discarded (push is forced to 0 during reset). Upstream flushes on reset, so no word is lost relative to the flushed state.
- init rising mid-operation: pops stop in that same cycle. A push already scheduled from the previous cycle still completes.
- A pop is never issued when the corresponding empty flag is high.

## Structure
- Shared package/include holds:
  - state encodings: RESET=2'd0, INIT=2'd1, IDLE=2'd2, ACTIVE=2'd3
  - the destination-bit index (data_width-1)
- Natural sub-module: arbiter_vc_grant. It is purely combinational, producing eligibility and grant from the empties, head MSBs, pauses, starve_cnt and state.
- The top level holds the FSM, starve_cnt and the output registers.

## Test plan
- **Reset/init:** hold reset 3 cycles with VC0 non-empty → all outputs 0. Then reset=0, init=1 for 2 cycles → no pops. Drop init → pop_VC0_fifo=1 next cycle, state reaches ACTIVE.
- **Priority and latency:** VC0 head 6'h05, VC1 head 6'h21, no pause → pop VC0 in cycle N; cycle N+1 push_D0=1, data_out_arbitro=6'h05.
- **Starvation:** both FIFOs continuously full, STARVE_LIMIT=4 → grant sequence VC0,VC0,VC0,VC0,VC1, repeating.
- **No head-of-line blocking:** pause_D1=1, VC0 head 6'h25 (→D1), VC1 head 6'h03 (→D0) → VC1 is popped and push_D0 carries 6'h03; VC0 is not popped until pause_D1 drops.
- **Empty boundary:** VC0 holds one word, VC1 empty → exactly one pop, then idle_out=1 on the cycle after the FIFO empties, with no further pops.
- **Reset mid-stream:** assert reset in the cycle after a pop → push forced to 0 and all state cleared in the next cycle.

Source files
------------

// File: rtl/arbiter_vc_pkg.sv
// Shared constants for the VC arbiter: FSM encodings and the
// destination-select bit position inside a data word.
package arbiter_vc_pkg;

  localparam logic [1:0] ST_RESET  = 2'd0;
  localparam logic [1:0] ST_INIT   = 2'd1;
  localparam logic [1:0] ST_IDLE   = 2'd2;
  localparam logic [1:0] ST_ACTIVE = 2'd3;

  localparam int DATA_WIDTH = 6;

  function automatic int dest_bit(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/arbiter_vc_grant.sv
// Combinational eligibility and grant: VC0 priority with a
// starvation guard that hands one grant to VC1 at the limit.
module arbiter_vc_grant
  import arbiter_vc_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic [1:0] state,
  input  logic       empty0,
  input  logic       empty1,
  input  logic       dest0,
  input  logic       dest1,
  input  logic       pause_d0,
  input  logic       pause_d1,
  input  logic [3:0] starve_cnt,
  output logic       elig1,
  output logic       grant0,
  output logic       grant1
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic run;
  logic elig0;
  logic starved;

  assign run     = (state == ST_IDLE) || (state == ST_ACTIVE);
  assign elig0   = !empty0 && !(dest0 ? pause_d1 : pause_d0);
  assign elig1   = !empty1 && !(dest1 ? pause_d1 : pause_d0);
  assign starved = (starve_cnt == LIMIT);

  assign grant0 = run && elig0 && !(elig1 && starved);
  assign grant1 = run && elig1 && (!elig0 || starved);

endmodule

// File: rtl/arbiter_vc.sv
// VC0/VC1 transmit arbiter: pops VC FIFO heads and pushes each
// word to D0/D1 one cycle later, chosen by the word's top bit.
module arbiter_vc
  import arbiter_vc_pkg::*;
#(
  parameter int data_width   = DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_fifo_VC0,
  input  logic                  empty_fifo_VC1,
  input  logic [data_width-1:0] data_arbitro_VC0,
  input  logic [data_width-1:0] data_arbitro_VC1,
  input  logic                  pause_D0,
  input  logic                  pause_D1,
  output logic                  pop_VC0_fifo,
  output logic                  pop_VC1_fifo,
  output logic                  push_D0,
  output logic                  push_D1,
  output logic [data_width-1:0] data_out_arbitro,
  output logic                  idle_out,
  output logic                  active_out
);

  localparam int DB = dest_bit(data_width);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [3:0]            starve_cnt;
  logic                  run;
  logic                  busy;
  logic                  elig1;
  logic                  grant0;
  logic                  grant1;
  logic                  pop_any;
  logic                  push0_q;
  logic                  push1_q;
  logic [data_width-1:0] head;

  arbiter_vc_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .state     (state),
    .empty0    (empty_fifo_VC0),
    .empty1    (empty_fifo_VC1),
    .dest0     (data_arbitro_VC0[DB]),
    .dest1     (data_arbitro_VC1[DB]),
    .pause_d0  (pause_D0),
    .pause_d1  (pause_D1),
    .starve_cnt(starve_cnt),
    .elig1     (elig1),
    .grant0    (grant0),
    .grant1    (grant1)
  );

  // init and reset stop pops in the very cycle they rise
  assign pop_VC0_fifo = grant0 && !reset && !init;
  assign pop_VC1_fifo = grant1 && !reset && !init;
  assign pop_any      = pop_VC0_fifo || pop_VC1_fifo;
  assign head         = pop_VC1_fifo ? data_arbitro_VC1
                                     : data_arbitro_VC0;

  assign run  = (state == ST_IDLE) || (state == ST_ACTIVE);
  assign busy = !empty_fifo_VC0 || !empty_fifo_VC1;

  // a word popped just before reset is discarded
  assign push_D0 = push0_q && !reset;
  assign push_D1 = push1_q && !reset;

  always_comb begin
    state_next = state;
    if (init) begin
      state_next = ST_INIT;
    end else begin
      case (state)
        ST_RESET: state_next = ST_IDLE;
        default:  state_next = busy ? ST_ACTIVE : ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_RESET;
      starve_cnt       <= '0;
      push0_q          <= 1'b0;
      push1_q          <= 1'b0;
      data_out_arbitro <= '0;
      idle_out         <= 1'b0;
      active_out       <= 1'b0;
    end else begin
      state      <= state_next;
      idle_out   <= (state_next == ST_IDLE);
      active_out <= (state_next == ST_ACTIVE);
      push0_q    <= pop_any && !head[DB];
      push1_q    <= pop_any && head[DB];
      if (pop_any) begin
        data_out_arbitro <= head;
      end
      if (!run || init || !elig1 || pop_VC1_fifo) begin
        starve_cnt <= '0;
      end else if (pop_VC0_fifo && starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_arbiter_vc.sv
// Bench for arbiter_vc: queue-backed VC FIFOs, behavioural model
// compared every cycle, plus directed literal scenarios.
module tb_arbiter_vc;

  localparam int W   = 6;
  localparam int LIM = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         init = 1'b0;
  logic         e0 = 1'b1;
  logic         e1 = 1'b1;
  logic [W-1:0] h0 = '0;
  logic [W-1:0] h1 = '0;
  logic         p0 = 1'b0;
  logic         p1 = 1'b0;
  logic         pop0, pop1, push0, push1, idle, active;
  logic [W-1:0] dout;

  // requested inputs for the next cycle, applied after the negedge
  bit r = 1'b1, ini = 1'b0, pp0 = 1'b0, pp1 = 1'b0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  int errors = 0;
  int checks = 0;

  typedef enum {M_RST, M_INIT, M_RUN} mph_t;
  mph_t         mph = M_RST;
  bit           m_push0 = 0, m_push1 = 0, m_idle = 0, m_active = 0;
  logic [W-1:0] m_data = '0;
  int           m_cnt = 0;

  always #5 clk = ~clk;

  arbiter_vc #(.data_width(W), .STARVE_LIMIT(LIM)) dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .empty_fifo_VC0  (e0),
    .empty_fifo_VC1  (e1),
    .data_arbitro_VC0(h0),
    .data_arbitro_VC1(h1),
    .pause_D0        (p0),
    .pause_D1        (p1),
    .pop_VC0_fifo    (pop0),
    .pop_VC1_fifo    (pop1),
    .push_D0         (push0),
    .push_D1         (push1),
    .data_out_arbitro(dout),
    .idle_out        (idle),
    .active_out      (active)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step();
    bit ok, el0, el1, g0, g1, idle_now;
    logic [W-1:0] hd;
    @(negedge clk);
    reset = r;
    init  = ini;
    p0    = pp0;
    p1    = pp1;
    e0    = (q0.size() == 0);
    e1    = (q1.size() == 0);
    h0    = e0 ? '0 : q0[0];
    h1    = e1 ? '0 : q1[0];
    #1;
    ok  = (mph == M_RUN) && !reset && !init;
    el0 = !e0 && !(h0[W-1] ? p1 : p0);
    el1 = !e1 && !(h1[W-1] ? p1 : p0);
    g0  = 0;
    g1  = 0;
    if (ok) begin
      if (el0 && el1) begin
        if (m_cnt == LIM) g1 = 1;
        else g0 = 1;
      end else begin
        g0 = el0;
        g1 = el1;
      end
    end
    chk("pop_VC0", pop0, g0);
    chk("pop_VC1", pop1, g1);
    chk("push_D0", push0, !reset && m_push0);
    chk("push_D1", push1, !reset && m_push1);
    chk("data_out", dout, m_data);
    chk("idle_out", idle, m_idle);
    chk("active_out", active, m_active);
    if (reset) begin
      mph = M_RST; m_push0 = 0; m_push1 = 0;
      m_data = '0; m_idle = 0; m_active = 0; m_cnt = 0;
    end else if (init) begin
      mph = M_INIT; m_push0 = 0; m_push1 = 0;
      m_idle = 0; m_active = 0; m_cnt = 0;
    end else begin
      idle_now = (mph == M_RST) ? 1'b1 : (e0 && e1);
      m_idle   = idle_now;
      m_active = !idle_now;
      mph      = M_RUN;
      hd       = g1 ? h1 : h0;
      m_push0  = (g0 || g1) && !hd[W-1];
      m_push1  = (g0 || g1) && hd[W-1];
      if (g0 || g1) m_data = hd;
      if (!ok || !el1 || g1) m_cnt = 0;
      else if (g0) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
    end
    if (g0) void'(q0.pop_front());
    if (g1) void'(q1.pop_front());
  endtask

  initial begin
    bit [9:0] seq;
    // reset with VC0 holding data
    q0 = '{6'h05};
    repeat (3) begin
      step();
      chk("rst_pop0", pop0, 0);
      chk("rst_push0", push0, 0);
      chk("rst_idle", idle, 0);
      chk("rst_data", dout, 0);
    end
    r = 0; ini = 1;
    q1 = '{6'h21};
    repeat (2) begin
      step();
      chk("init_pop0", pop0, 0);
    end
    ini = 0;
    step();
    step();
    chk("prio_pop0", pop0, 1);
    chk("prio_pop1", pop1, 0);
    chk("post_init_active", active, 1);
    step();
    chk("lat_push_D0", push0, 1);
    chk("lat_data", dout, 6'h05);
    chk("prio_pop1_next", pop1, 1);
    step();
    chk("lat_push_D1", push1, 1);
    chk("lat_data1", dout, 6'h21);
    repeat (3) step();

    // starvation guard
    for (int i = 0; i < 12; i++) begin
      q0.push_back(W'($urandom_range(0, 31)));
      q1.push_back(W'($urandom_range(0, 31)));
    end
    seq = '0;
    repeat (10) begin
      step();
      seq = {seq[8:0], pop1};
    end
    chk("starve_seq", seq, 10'b0000100001);
    q0.delete(); q1.delete();
    repeat (3) step();

    // no head-of-line blocking
    pp1 = 1;
    q0 = '{6'h25};
    q1 = '{6'h03};
    step();
    chk("hol_pop1", pop1, 1);
    chk("hol_pop0", pop0, 0);
    step();
    chk("hol_push_D0", push0, 1);
    chk("hol_data", dout, 6'h03);
    chk("hol_blocked", pop0, 0);
    pp1 = 0;
    step();
    chk("hol_release", pop0, 1);
    step();
    chk("hol_push_D1", push1, 1);
    chk("hol_data1", dout, 6'h25);
    repeat (3) step();

    // empty boundary
    q0 = '{6'h0A};
    step();
    chk("one_pop", pop0, 1);
    step();
    chk("empty_nopop", pop0, 0);
    step();
    chk("empty_idle", idle, 1);
    chk("empty_nopop2", pop0, 0);

    // reset mid-stream
    q0 = '{6'h11, 6'h12, 6'h13};
    step();
    chk("mid_pop", pop0, 1);
    r = 1;
    q0.delete();
    step();
    chk("mid_push_forced", push0, 0);
    r = 0;
    step();
    chk("mid_data_clr", dout, 0);
    chk("mid_push_clr", push0, 0);
    chk("mid_active_clr", active, 0);

    // randomized traffic
    repeat (3000) begin
      pp0 = ($urandom_range(0, 3) == 0);
      pp1 = ($urandom_range(0, 3) == 0);
      ini = ($urandom_range(0, 99) == 0);
      r   = ($urandom_range(0, 299) == 0);
      if (r) begin
        q0.delete(); q1.delete();
      end
      if ($urandom_range(0, 2) != 0 && q0.size() < 8)
        q0.push_back(W'($urandom_range(0, 63)));
      if ($urandom_range(0, 2) != 0 && q1.size() < 8)
        q1.push_back(W'($urandom_range(0, 63)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
